red_pitaya_pfd_freq_counter: RTL and testbench
==============================================

# red_pitaya_pfd_freq_counter

Gated frequency counter placed directly downstream of the CORDIC phase detector. It takes the detector's wrapped phase word (turn fraction, LSB = 2^-PHASEWIDTH turn) and computes the wrapped per-sample phase increment. It sums the increments over a programmable window of 2^gate clock cycles and reports the total phase advance with a one-cycle valid strobe. Single-shot and gapless continuous modes are supported.

## Interface
- PHASEWIDTH, 12: width of the phase fraction input (turn fraction).
- MAXGATELOG2, 24: largest supported window exponent.
- ACCWIDTH, 36: accumulator and output width; must equal PHASEWIDTH+MAXGATELOG2.
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  reset, asynchronous, active-high.
- phase_i  in  PHASEWIDTH  unsigned phase fraction; sampled every cycle.
- gate_log2_i  in  5  window exponent; window length N = 2^g.
- start_i  in  1  arms one measurement; honoured only in IDLE.
- continuous_i  in  1  when high at window end, the next window starts with no gap.
- abort_i  in  1  returns to IDLE; no result is produced.
- freq_o  out  ACCWIDTH  signed result (see Configuration).
- freq_valid_o  out  1  one-cycle strobe when freq_o updates.
- busy_o  out  1  high in PRIME and COUNT.
- seq_o  out  8  result counter; increments with each freq_valid_o and wraps 255→0.

## Operation
- Effective exponent g = clamp(gate_log2_i, 2, MAXGATELOG2). g is latched on entry to PRIME and on every continuous re-arm. Changes to gate_log2_i mid-window are ignored.
- Increment: delta = signed(phase_i − prev), computed modulo 2^PHASEWIDTH. The range is [−2^(P−1), 2^(P−1)−1], so an exactly half-turn increment reads as negative.
- The accumulator is a signed ACCWIDTH value and cannot overflow, because |sum| ≤ 2^(P−1)·2^MAXGATELOG2.
- States:
  - IDLE: start_i → PRIME.
  - PRIME: prev←phase_i, acc←0, cnt←N−1 → COUNT.
  - COUNT: acc←acc+delta, prev←phase_i, cnt←cnt−1.
  - COUNT with cnt==0: freq_o←acc+delta, freq_valid_o←1, seq_o+1. Then:
    - if continuous_i: acc←0, cnt←N−1, stay in COUNT;
    - otherwise go to IDLE.
- abort_i has priority over every transition. It forces IDLE and no strobe is emitted. freq_o and seq_o hold their values.
- start_i outside IDLE is ignored. start_i and abort_i high together in IDLE → stay in IDLE.
- Reset values: all outputs are 0, state is IDLE, acc, cnt and prev are 0.
- Reset asserted mid-window discards the window. No strobe is emitted.

## Timing
- Edge E0 samples start_i in IDLE. E1 is PRIME. Edges E2..E(N+1) accumulate N increments.
- freq_valid_o is high for exactly the cycle following E(N+1).
- Single-shot latency: start to strobe is N+1 cycles after E0.
- Continuous mode: consecutive strobes are exactly N cycles apart. Every phase sample contributes to exactly one window, so there are no gaps or overlaps.
- busy_o is high from E0+1 through the cycle of the last accumulation edge. It drops together with the strobe when the window ends single-shot.
- freq_o is registered and holds its value between strobes.

## Configuration
- PFD_FREQ_AVG_EN defined: freq_o = (sum + 2^(g−1)) >>> g, an arithmetic shift with round-half-up. This is the mean increment per cycle in 2^-PHASEWIDTH turn units, sign-extended to ACCWIDTH.
- PFD_FREQ_AVG_EN undefined: freq_o = raw sum over the window. No rounding logic is synthesised.

## Test plan
- **Constant increment:** phase_i increments by +5 per cycle, g=4, single shot. Required: freq_valid_o 17 cycles after the start edge; freq_o = 80 (raw) or 5 (avg); seq_o = 1; then IDLE.
- **Wrap-around:** phase_i decrements by 3 per cycle, starting at 2 so it crosses 0, g=4. Required: freq_o = −48 (raw) or −3 (avg).
- **Half turn:** increment 2048 per cycle, g=2. Required: delta = −2048, freq_o = −8192 (raw).
- **Continuous mode:** increment +1, g=3, continuous_i held high; switch to +2 exactly at a window boundary. Required: strobes every 8 cycles; results 8 then 16 (raw); seq_o counts 1, 2, 3...
- **Abort:** abort_i pulsed at cycle 5 of a g=4 window. Required: no strobe; busy_o low next cycle; freq_o unchanged; a new start measures correctly.
- **Reset and clamps:** rst_i asserted mid-window, asynchronously. Required: all outputs 0 immediately. Then gate_log2_i=0 behaves as g=2, and gate_log2_i=31 behaves as g=24.

Source files
------------

// File: rtl/red_pitaya_pfd_freq_counter.sv
// red_pitaya_pfd_freq_counter
// Gated frequency counter fed by the CORDIC phase detector. It differentiates
// the wrapped phase word into signed per-sample increments and sums them over
// a window of 2^g clock cycles. The total phase advance is reported with a
// one-cycle valid strobe. Single-shot and gapless continuous modes are
// supported.
//
// Build option: define PFD_FREQ_AVG_EN to report the rounded mean increment
// per cycle, (sum + 2^(g-1)) >>> g, instead of the raw window sum.
//
// Handshake: start_i is a level sampled on each clk_i edge and acted on only
// in IDLE. abort_i has priority over start_i. freq_valid_o is high for
// exactly one cycle per completed window, and freq_o holds its value between
// strobes. There is no back-pressure.
module red_pitaya_pfd_freq_counter #(
    parameter int PHASEWIDTH  = 12,
    parameter int MAXGATELOG2 = 24,
    parameter int ACCWIDTH    = 36
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PHASEWIDTH-1:0] phase_i,
    input  logic [4:0]            gate_log2_i,
    input  logic                  start_i,
    input  logic                  continuous_i,
    input  logic                  abort_i,
    output logic [ACCWIDTH-1:0]   freq_o,
    output logic                  freq_valid_o,
    output logic                  busy_o,
    output logic [7:0]            seq_o
);

    localparam int CW = MAXGATELOG2;
    localparam logic [4:0] G_MIN = 5'd2;
    localparam logic [4:0] G_MAX = 5'(MAXGATELOG2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [PHASEWIDTH-1:0] prev_q;
    logic [ACCWIDTH-1:0]   acc_q;
    logic [CW-1:0]         cnt_q;
    logic [4:0]            g_q;

    logic [4:0]            g_clamped;
    logic [PHASEWIDTH-1:0] diff;
    logic [ACCWIDTH-1:0]   delta_ext;
    logic [ACCWIDTH-1:0]   sum_full;
    logic [ACCWIDTH-1:0]   result;
    logic                  last_sample;

    // Window length minus one for exponent g. At g == CW the shift wraps
    // to zero and the subtraction yields the all-ones maximum count.
    function automatic logic [CW-1:0] window_last(input logic [4:0] g);
        return (CW'(1) << g) - CW'(1);
    endfunction

    // Clamp the requested window exponent into the supported range.
    always_comb begin
        g_clamped = gate_log2_i;
        if (gate_log2_i < G_MIN) begin
            g_clamped = G_MIN;
        end else if (gate_log2_i > G_MAX) begin
            g_clamped = G_MAX;
        end
    end

    // Wrapped phase increment, sign-extended, plus the running window sum.
    // A half-turn step lands on the most negative code by construction.
    always_comb begin
        diff        = phase_i - prev_q;
        delta_ext   = {{(ACCWIDTH-PHASEWIDTH){diff[PHASEWIDTH-1]}}, diff};
        sum_full    = acc_q + delta_ext;
        last_sample = (state_q == ST_COUNT) && (cnt_q == '0);
    end

`ifdef PFD_FREQ_AVG_EN
    logic signed [ACCWIDTH-1:0] rounded;

    // Mean increment per cycle: round half up, then arithmetic shift by g.
    always_comb begin
        rounded = $signed(sum_full + (ACCWIDTH'(1) << (g_q - 5'd1)));
        result  = ACCWIDTH'(rounded >>> g_q);
    end
`else
    // Raw window sum is reported unchanged.
    always_comb begin
        result = sum_full;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: abort wins over everything, including a start in IDLE.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_i) state_d = ST_PRIME;
                ST_PRIME: state_d = ST_COUNT;
                ST_COUNT: if (last_sample && !continuous_i) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: busy covers the priming cycle and every accumulation cycle.
    always_comb begin
        busy_o = (state_q != ST_IDLE);
    end

    // Datapath: phase history, accumulator, window counter, result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            g_q          <= G_MIN;
            freq_o       <= '0;
            freq_valid_o <= 1'b0;
            seq_o        <= '0;
        end else begin
            freq_valid_o <= 1'b0;
            if (!abort_i) begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            g_q <= g_clamped;
                        end
                    end
                    ST_PRIME: begin
                        prev_q <= phase_i;
                        acc_q  <= '0;
                        cnt_q  <= window_last(g_q);
                    end
                    ST_COUNT: begin
                        prev_q <= phase_i;
                        if (cnt_q == '0) begin
                            freq_o       <= result;
                            freq_valid_o <= 1'b1;
                            seq_o        <= seq_o + 8'd1;
                            acc_q        <= '0;
                            if (continuous_i) begin
                                g_q   <= g_clamped;
                                cnt_q <= window_last(g_clamped);
                            end
                        end else begin
                            acc_q <= sum_full;
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: begin
                        acc_q <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_pfd_freq_counter.sv
// Directed bench for red_pitaya_pfd_freq_counter: vector table of
// single-shot windows plus hand-written continuous, abort, reset and
// clamp sequences.
module tb_red_pitaya_pfd_freq_counter;

    localparam int PW = 12;
    localparam int AW = 36;

    // ---------------- clock / reset ----------------
    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [PW-1:0] phase_i = '0;
    logic [4:0]    gate_log2_i = '0;
    logic          start_i = 1'b0;
    logic          continuous_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [AW-1:0] freq_o;
    logic          freq_valid_o;
    logic          busy_o;
    logic [7:0]    seq_o;

    always #5 clk_i = ~clk_i;

    red_pitaya_pfd_freq_counter #(
        .PHASEWIDTH (PW),
        .MAXGATELOG2(24),
        .ACCWIDTH   (AW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .phase_i     (phase_i),
        .gate_log2_i (gate_log2_i),
        .start_i     (start_i),
        .continuous_i(continuous_i),
        .abort_i     (abort_i),
        .freq_o      (freq_o),
        .freq_valid_o(freq_valid_o),
        .busy_o      (busy_o),
        .seq_o       (seq_o)
    );

    // ---------------- scoreboard ----------------
    logic [AW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            exp_seq = 0;
    longint        last_exp = 0;
    logic [PW-1:0] inc = '0;

    typedef struct {
        logic [PW-1:0] inc;
        logic [PW-1:0] phase0;
        logic [4:0]    gate;
        int            g;
        longint        raw;
        longint        avg;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: wait for the edge, settle, then advance the phase ramp.
    task automatic step();
        @(posedge clk_i);
        #1;
        phase_i = phase_i + inc;
    endtask

    function automatic longint pick(input longint raw, input longint avg);
`ifdef PFD_FREQ_AVG_EN
        return avg;
`else
        return raw;
`endif
    endfunction

    // Compare a strobe against the head of the expected queue.
    task automatic score(input string name);
        logic [AW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected strobe got %0d expected none", name, $signed(freq_o));
        end else begin
            e = exp_q.pop_front();
            check({name, "_freq"}, longint'($signed(freq_o)), longint'($signed(e)));
            exp_seq = (exp_seq + 1) % 256;
            check({name, "_seq"}, longint'(seq_o), longint'(exp_seq));
        end
    endtask

    // Single-shot window from a table entry, including latency and pulse width.
    task automatic run_vector(input int idx);
        int     n;
        bit     got;
        longint e;
        n = 1 << vecs[idx].g;
        e = pick(vecs[idx].raw, vecs[idx].avg);
        inc = vecs[idx].inc;
        phase_i = vecs[idx].phase0;
        gate_log2_i = vecs[idx].gate;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        gate_log2_i = 5'd3;
        exp_q.push_back(AW'(e));
        got = 1'b0;
        for (int cyc = 1; cyc <= n + 4; cyc++) begin
            step();
            if (cyc == 1) check($sformatf("v%0d_busy", idx), longint'(busy_o), 1);
            if (freq_valid_o) begin
                check($sformatf("v%0d_latency", idx), cyc, n + 1);
                score($sformatf("v%0d", idx));
                check($sformatf("v%0d_busy_end", idx), longint'(busy_o), 0);
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL v%0d_timeout: got no strobe expected one within %0d cycles", idx, n + 4);
            void'(exp_q.pop_front());
        end
        step();
        check($sformatf("v%0d_pulse", idx), longint'(freq_valid_o), 0);
        check($sformatf("v%0d_hold", idx), longint'($signed(freq_o)), e);
        last_exp = e;
    endtask

    initial begin
        // inc, phase0, gate, effective g, raw sum, rounded mean
        vecs[0] = '{12'd5,    12'd0,    5'd4, 4, 80,    5};
        vecs[1] = '{12'd4093, 12'd2,    5'd4, 4, -48,   -3};
        vecs[2] = '{12'd2048, 12'd0,    5'd2, 2, -8192, -2048};
        vecs[3] = '{12'd4095, 12'd0,    5'd5, 5, -32,   -1};
        vecs[4] = '{12'd100,  12'd1000, 5'd6, 6, 6400,  100};
        vecs[5] = '{12'd7,    12'd0,    5'd0, 2, 28,    7};
        vecs[6] = '{12'd9,    12'd4000, 5'd1, 2, 36,    9};

        // Reset state
        step();
        step();
        check("rst_freq", longint'(freq_o), 0);
        check("rst_valid", longint'(freq_valid_o), 0);
        check("rst_busy", longint'(busy_o), 0);
        check("rst_seq", longint'(seq_o), 0);
        rst_i = 1'b0;
        step();

        for (int i = 0; i <= 4; i++) run_vector(i);

        // Abort at cycle 5 of a g=4 window
        begin
            bit seen;
            inc = 12'd5;
            gate_log2_i = 5'd4;
            start_i = 1'b1;
            step();
            start_i = 1'b0;
            for (int c = 1; c <= 5; c++) step();
            abort_i = 1'b1;
            step();
            abort_i = 1'b0;
            check("abort_busy", longint'(busy_o), 0);
            seen = 1'b0;
            for (int c = 0; c < 24; c++) begin
                if (freq_valid_o) seen = 1'b1;
                step();
            end
            check("abort_nostrobe", longint'(seen), 0);
            check("abort_freq", longint'($signed(freq_o)), last_exp);
            check("abort_seq", longint'(seq_o), longint'(exp_seq));
            start_i = 1'b1;
            abort_i = 1'b1;
            step();
            start_i = 1'b0;
            abort_i = 1'b0;
            step();
            check("start_abort_idle", longint'(busy_o), 0);
            run_vector(0);
        end

        // Continuous mode: +1 then +2 from the second window, g=3
        begin
            int k;
            inc = 12'd1;
            gate_log2_i = 5'd3;
            continuous_i = 1'b1;
            start_i = 1'b1;
            step();
            start_i = 1'b0;
            exp_q.push_back(AW'(pick(8, 1)));
            exp_q.push_back(AW'(pick(16, 2)));
            exp_q.push_back(AW'(pick(16, 2)));
            k = 0;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                step();
                if (freq_valid_o) begin
                    check($sformatf("cont%0d_time", k), cyc, 9 + 8 * k);
                    score($sformatf("cont%0d", k));
                    k++;
                end
                if (cyc == 8) inc = 12'd2;
                if (cyc == 17) continuous_i = 1'b0;
                if (cyc == 25) check("cont_end_busy", longint'(busy_o), 0);
            end
            check("cont_count", k, 3);
            exp_q.delete();
        end

        // Asynchronous reset mid-window
        inc = 12'd5;
        gate_log2_i = 5'd4;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 0; c < 5; c++) step();
        #3;
        rst_i = 1'b1;
        #1;
        check("arst_freq", longint'(freq_o), 0);
        check("arst_busy", longint'(busy_o), 0);
        check("arst_seq", longint'(seq_o), 0);
        check("arst_valid", longint'(freq_valid_o), 0);
        step();
        rst_i = 1'b0;
        exp_seq = 0;
        step();

        // Exponent clamps
        run_vector(5);
        run_vector(6);
        begin
            bit seen;
            inc = 12'd1;
            gate_log2_i = 5'd31;
            start_i = 1'b1;
            step();
            start_i = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 300; c++) begin
                step();
                if (freq_valid_o) seen = 1'b1;
            end
            check("clamp_hi_nostrobe", longint'(seen), 0);
            check("clamp_hi_busy", longint'(busy_o), 1);
            abort_i = 1'b1;
            step();
            abort_i = 1'b0;
            check("clamp_hi_abort", longint'(busy_o), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
